// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush controller for the five-stage pipeline. Drives the
//   enable and synchronous-clear inputs of the PC and the IF/ID, ID/EX,
//   EX/MEM and MEM/WB registers. Resolves, in fixed priority order: reset,
//   data-memory wait states, multi-cycle MDU ops, EX redirects and load-use
//   hazards. Keeps saturating stall-cycle and redirect-flush counters.
//
//   Ports
//     clk, reset                 clock, synchronous active-high reset
//     id_rs1/id_rs2              ID source registers, qualified by id_uses_rs1/2
//     ex_rd, ex_mem_read         EX destination register, EX is a load
//     ex_redirect                EX is a taken branch / jump
//     ex_mdu_start               EX holds a multi-cycle MDU op
//     mem_ready                  data memory completes this cycle
//     *_en, *_flush              pipeline register enables / clears
//     mdu_busy                   MDU FSM not idle
//     stall_cycles               cycles with pc_en low (saturating)
//     redirect_flushes           redirects acted on (saturating)
module pipeline_hazard_ctrl #(
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             ex_mdu_start,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_flushes
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;

  // The start cycle is itself a stall cycle, so BUSY covers the other
  // MDU_LATENCY-1 cycles: counting down from LATENCY-2 to 0 inclusive.
  localparam logic [4:0] CNT_LOAD = 5'(MDU_LATENCY - 2);

  mdu_state_t state;
  logic [4:0] cnt;
  logic       load_use;
  logic       mdu_stall;
  logic       redirect_take;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign mdu_stall = ((state == IDLE) && ex_mdu_start && mem_ready) ||
                     (state == BUSY);

  always_comb begin
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    redirect_take = 1'b0;
    if (reset || !mem_ready) begin
      // whole pipe frozen; pending redirect/load-use re-evaluated next cycle
    end else if (mdu_stall) begin
      // front end holds; a bubble is cleared into MEM while WB drains
      ex_mem_en    = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_en    = 1'b1;
    end else if (ex_redirect) begin
      // ID instruction is killed, so any load-use against it is moot
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      id_ex_en      = 1'b1;
      ex_mem_en     = 1'b1;
      mem_wb_en     = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      redirect_take = 1'b1;
    end else if (load_use) begin
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
    end else begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mdu_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_mdu_start && mem_ready) begin
            state    <= BUSY;
            cnt      <= CNT_LOAD;
            mdu_busy <= 1'b1;
          end
        end
        BUSY: begin
          // advances even during memory wait states
          if (cnt == 5'd0) state <= DONE;
          else             cnt   <= cnt - 5'd1;
        end
        DONE: begin
          // ex_mdu_start ignored here so the finishing op cannot re-trigger
          if (mem_ready) begin
            state    <= IDLE;
            mdu_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          mdu_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles     <= '0;
      redirect_flushes <= '0;
    end else begin
      if (!pc_en && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (redirect_take && (redirect_flushes != '1))
        redirect_flushes <= redirect_flushes + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl. Two instances share all inputs:
// A (MDU_LATENCY=4, CNT_W=8) and B (MDU_LATENCY=12, CNT_W=2). A behavioural
// model tracks each MDU op by its age in cycles and keeps unbounded counters
// that are clipped to the counter width on compare.
module tb_pipeline_hazard_ctrl;
  localparam int L0 = 4;
  localparam int W0 = 8;
  localparam int L1 = 12;
  localparam int W1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, ex_mdu_start, mem_ready;

  // en = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id, id_ex, ex_mem}
  logic [4:0]    en_a, en_b;
  logic [2:0]    fl_a, fl_b;
  logic          busy_a, busy_b;
  logic [W0-1:0] sc_a, rf_a;
  logic [W1-1:0] sc_b, rf_b;

  pipeline_hazard_ctrl #(.MDU_LATENCY(L0), .CNT_W(W0)) dut_a (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_mdu_start(ex_mdu_start),
    .mem_ready(mem_ready), .pc_en(en_a[4]), .if_id_en(en_a[3]), .id_ex_en(en_a[2]),
    .ex_mem_en(en_a[1]), .mem_wb_en(en_a[0]), .if_id_flush(fl_a[2]),
    .id_ex_flush(fl_a[1]), .ex_mem_flush(fl_a[0]), .mdu_busy(busy_a),
    .stall_cycles(sc_a), .redirect_flushes(rf_a));

  pipeline_hazard_ctrl #(.MDU_LATENCY(L1), .CNT_W(W1)) dut_b (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_mdu_start(ex_mdu_start),
    .mem_ready(mem_ready), .pc_en(en_b[4]), .if_id_en(en_b[3]), .id_ex_en(en_b[2]),
    .ex_mem_en(en_b[1]), .mem_wb_en(en_b[0]), .if_id_flush(fl_b[2]),
    .id_ex_flush(fl_b[1]), .ex_mem_flush(fl_b[0]), .mdu_busy(busy_b),
    .stall_cycles(sc_b), .redirect_flushes(rf_b));

  int tests = 0;
  int fails = 0;

  // model: age 0 = no op; ages 1..L-1 stalling; age L = finished, waiting on memory
  int     age [2];
  longint msc [2];
  longint mrf [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lat(input int k);
    return (k == 0) ? L0 : L1;
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  // mask drops enables whose value is irrelevant because a flush overrides them
  function automatic void model_out(input int k, output logic [4:0] en, output logic [2:0] fl,
                                    output logic [4:0] mk, output bit redir);
    bit lu, ms;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    ms = (age[k] == 0 && ex_mdu_start && mem_ready) || (age[k] >= 1 && age[k] < lat(k));
    mk = 5'b11111; redir = 1'b0;
    if (reset || !mem_ready) begin en = 5'b00000; fl = 3'b000; end
    else if (ms)          begin en = 5'b00011; fl = 3'b001; mk = 5'b11101; end
    else if (ex_redirect) begin en = 5'b11111; fl = 3'b110; redir = 1'b1; end
    else if (lu)          begin en = 5'b00111; fl = 3'b010; mk = 5'b11011; end
    else                  begin en = 5'b11111; fl = 3'b000; end
  endfunction

  task automatic compare_all();
    logic [4:0] en, mk;
    logic [2:0] fl;
    bit rd;
    for (int k = 0; k < 2; k++) begin
      model_out(k, en, fl, mk, rd);
      chk($sformatf("en%0d", k), 64'(((k == 0) ? en_a : en_b) & mk), 64'(en & mk));
      chk($sformatf("fl%0d", k), 64'((k == 0) ? fl_a : fl_b), 64'(fl));
      chk($sformatf("busy%0d", k), 64'((k == 0) ? busy_a : busy_b), 64'(age[k] != 0));
      chk($sformatf("stall_cycles%0d", k), (k == 0) ? 64'(sc_a) : 64'(sc_b),
          64'(sat(msc[k], (k == 0) ? W0 : W1)));
      chk($sformatf("redirect_flushes%0d", k), (k == 0) ? 64'(rf_a) : 64'(rf_b),
          64'(sat(mrf[k], (k == 0) ? W0 : W1)));
    end
  endtask

  task automatic update_model();
    logic [4:0] en, mk;
    logic [2:0] fl;
    bit rd;
    for (int k = 0; k < 2; k++) begin
      model_out(k, en, fl, mk, rd);
      if (reset) begin
        age[k] = 0; msc[k] = 0; mrf[k] = 0;
      end else begin
        if (!en[4]) msc[k]++;
        if (rd) mrf[k]++;
        if (age[k] == 0) begin
          if (ex_mdu_start && mem_ready) age[k] = 1;
        end else if (age[k] < lat(k)) age[k]++;
        else if (mem_ready) age[k] = 0;
      end
    end
  endtask

  // entered at a negedge with inputs already applied
  task automatic cycle();
    #1;
    compare_all();
    update_model();
    @(negedge clk);
  endtask

  task automatic idle_in();
    reset = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_redirect = 1'b0; ex_mdu_start = 1'b0;
    mem_ready = 1'b1;
  endtask

  task automatic load_use_in();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
  endtask

  task automatic do_reset();
    idle_in(); reset = 1'b1; cycle(); reset = 1'b0;
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin age[k] = 0; msc[k] = 0; mrf[k] = 0; end
    // reset state
    #1;
    chk("rst_en", 64'(en_a), 64'd0);
    chk("rst_fl", 64'(fl_a), 64'd0);
    chk("rst_sc", 64'(sc_a), 64'd0);
    cycle();

    // 1: load-use and its two non-hazard variants
    idle_in(); load_use_in();
    #1;
    chk("lu_pc_en", 64'(en_a[4]), 64'd0);
    chk("lu_if_id_en", 64'(en_a[3]), 64'd0);
    chk("lu_id_ex_flush", 64'(fl_a[1]), 64'd1);
    chk("lu_ex_mem_en", 64'(en_a[1]), 64'd1);
    cycle();
    ex_rd = 5'd0; id_rs1 = 5'd0;
    #1; chk("lu_rd0_pc_en", 64'(en_a[4]), 64'd1);
    cycle();
    load_use_in(); id_uses_rs1 = 1'b0;
    #1; chk("lu_nouse_pc_en", 64'(en_a[4]), 64'd1);
    cycle();

    // 2: MDU op, latency 4, relative cycle 0 = op enters EX
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      idle_in(); ex_mdu_start = (c <= 4);
      #1;
      chk($sformatf("mdu_pc_en_c%0d", c), 64'(en_a[4]), 64'(c > 3));
      chk($sformatf("mdu_exmem_flush_c%0d", c), 64'(fl_a[0]), 64'(c <= 3));
      chk($sformatf("mdu_busy_c%0d", c), 64'(busy_a), 64'(c >= 1 && c <= 4));
      if (c == 4) chk("mdu_done_en", 64'(en_a), 64'h1f);
      if (c == 5) chk("mdu_stall_cycles", 64'(sc_a), 64'd4);
      cycle();
    end

    // 3: redirect together with load-use
    do_reset();
    idle_in(); load_use_in(); ex_redirect = 1'b1;
    #1;
    chk("rl_flush", 64'(fl_a), 64'b110);
    chk("rl_pc_en", 64'(en_a[4]), 64'd1);
    cycle();
    idle_in();
    #1;
    chk("rl_redirects", 64'(rf_a), 64'd1);
    chk("rl_stalls", 64'(sc_a), 64'd0);
    cycle();

    // 4: memory wait state with a pending redirect
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      idle_in(); ex_redirect = (c <= 3); mem_ready = (c >= 3);
      #1;
      if (c <= 2) begin
        chk($sformatf("mw_en_c%0d", c), 64'(en_a), 64'd0);
        chk($sformatf("mw_fl_c%0d", c), 64'(fl_a), 64'd0);
      end
      if (c == 3) chk("mw_flush", 64'(fl_a), 64'b110);
      if (c == 4) begin
        chk("mw_redirects", 64'(rf_a), 64'd1);
        chk("mw_stalls", 64'(sc_a), 64'd3);
      end
      cycle();
    end

    // 5: DONE held by memory wait state, no re-stall
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      idle_in(); ex_mdu_start = (c <= 6); mem_ready = !(c == 4 || c == 5);
      #1;
      if (c == 4 || c == 5) chk($sformatf("dh_busy_c%0d", c), 64'(busy_a), 64'd1);
      if (c == 6) begin
        chk("dh_no_restall", 64'(en_a), 64'h1f);
        chk("dh_busy_c6", 64'(busy_a), 64'd1);
      end
      if (c == 7) begin
        chk("dh_idle", 64'(busy_a), 64'd0);
        chk("dh_stalls", 64'(sc_a), 64'd6);
      end
      cycle();
    end

    // 6: reset while instance B counter is 7, then counter saturation at width 2
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      idle_in(); ex_mdu_start = (c <= 3); reset = (c == 4);
      cycle();
    end
    idle_in();
    #1;
    chk("rb_busy", 64'(busy_b), 64'd0);
    chk("rb_stalls", 64'(sc_b), 64'd0);
    chk("rb_redirects", 64'(rf_b), 64'd0);
    cycle();
    for (int c = 0; c < 5; c++) begin idle_in(); load_use_in(); cycle(); end
    idle_in();
    #1;
    chk("sat_b", 64'(sc_b), 64'd3);
    chk("nosat_a", 64'(sc_a), 64'd5);
    cycle();

    // randomized traffic, model-checked every cycle
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(99) == 0);
      id_rs1       = 5'($urandom_range(3));
      id_rs2       = 5'($urandom_range(3));
      ex_rd        = 5'($urandom_range(3));
      id_uses_rs1  = 1'($urandom_range(1));
      id_uses_rs2  = 1'($urandom_range(1));
      ex_mem_read  = ($urandom_range(2) == 0);
      ex_redirect  = ($urandom_range(6) == 0);
      ex_mdu_start = ($urandom_range(19) == 0);
      mem_ready    = ($urandom_range(4) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It drives the `enable` and flush (synchronous clear) inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, which are the control end of their enable/reset interface. It resolves data-memory wait states, multi-cycle MDU operations, EX-stage control-flow redirects and load-use hazards in a fixed priority order. It also keeps saturating stall and flush performance counters.

## Interface

**Parameters**
- `MDU_LATENCY`, default 32: total stall cycles for one MDU op. Legal range is ≥ 2.
- `CNT_W`, default 32: width of the performance counters.

**Ports**
- `clk` in, 1: clock.
- `reset` in, 1: synchronous, active-high.
- `id_rs1`, `id_rs2` in, 5 each: source register addresses of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in, 1 each: the ID instruction actually reads that source.
- `ex_rd` in, 5: destination register of the instruction in EX.
- `ex_mem_read` in, 1: the EX instruction is a load.
- `ex_redirect` in, 1: the EX instruction is a taken branch or a jump.
- `ex_mdu_start` in, 1: the EX instruction is a multi-cycle MDU op.
- `mem_ready` in, 1: the data memory completes this cycle. 0 means wait state.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` out, 1 each: register enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush` out, 1 each: synchronous clear. At the register, flush has priority over enable.
- `mdu_busy` out, 1: the MDU FSM is not IDLE.
- `stall_cycles` out, `CNT_W`: number of cycles with `pc_en`=0.
- `redirect_flushes` out, `CNT_W`: number of redirects acted on.

## Operation

**MDU FSM: states IDLE, BUSY, DONE; 5-bit down-counter `cnt`.**
- IDLE:
  - If `ex_mdu_start` & `mem_ready`, go to BUSY and load `cnt` = `MDU_LATENCY`-2.
  - The MDU stall is asserted in this cycle.
- BUSY:
  - The MDU stall is asserted.
  - If `cnt`==0, go to DONE; otherwise decrement `cnt`.
  - The counter advances regardless of `mem_ready`.
- DONE:
  - No MDU stall; the op leaves EX.
  - Return to IDLE only when `mem_ready`=1; otherwise hold in DONE.
  - `ex_mdu_start` is ignored in DONE, so the same op cannot re-trigger.
- `mdu_stall` = (IDLE & `ex_mdu_start` & `mem_ready`) | BUSY.

**Load-use hazard**
- `load_use` = `ex_mem_read` & (`ex_rd`≠0) & ((`id_uses_rs1` & `id_rs1`==`ex_rd`) | (`id_uses_rs2` & `id_rs2`==`ex_rd`)).

**Priority (outputs are combinational from state and inputs; first match wins)**
1. `reset`=1:
   - All enables 0, all flushes 0.
2. `mem_ready`=0:
   - All enables 0, all flushes 0. The whole pipe freezes.
   - A redirect or load-use seen this cycle is re-evaluated next cycle, because the EX register holds.
3. `mdu_stall`:
   - `pc_en`, `if_id_en` and `id_ex_en` are 0.
   - `ex_mem_flush`=1 (bubble into MEM).
   - `mem_wb_en`=1.
   - `ex_redirect` is ignored.
4. `ex_redirect`:
   - All enables 1.
   - `if_id_flush`=1 and `id_ex_flush`=1.
   - Any simultaneous load-use is dropped, because the ID instruction is being killed.
5. `load_use`:
   - `pc_en`=0 and `if_id_en`=0.
   - `id_ex_flush`=1 (bubble into EX).
   - `ex_mem_en` and `mem_wb_en` are 1.
6. Otherwise:
   - All enables 1, all flushes 0.

**Counters**
- `stall_cycles` increments when `pc_en`=0 and `reset`=0.
- `redirect_flushes` increments when priority 4 is taken.
- Both saturate at all-ones.

## Timing

- Reset values:
  - FSM in IDLE, `cnt`=0, `mdu_busy`=0.
  - `stall_cycles` and `redirect_flushes` are 0.
  - All enables and flushes are 0 while `reset` is high.
- Reset mid-MDU-op returns the FSM to IDLE in the next cycle, and the counters clear.
- Control outputs have zero latency (same cycle as the inputs). FSM and counters update on the rising edge of `clk`.
- MDU timing, for an op entering EX at cycle t with `mem_ready` held 1:
  - Stall cycles are t … t+`MDU_LATENCY`-1, exactly `MDU_LATENCY` cycles.
  - DONE is at t+`MDU_LATENCY`, when EX advances.
  - `mdu_busy` is high for cycles t+1 … t+`MDU_LATENCY`.
- Load-use stalls exactly 1 cycle. In the next cycle EX holds the bubble, so `ex_mem_read`=0 and the hazard clears.
- A redirect produces exactly 2 flushed slots (IF/ID and ID/EX) in the single cycle it is acted on.

## Test plan

1. **Load-use.** `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5, `id_uses_rs1`=1, `mem_ready`=1.
   - Response: `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1, `ex_mem_en`=1.
   - Repeat with `ex_rd`=0: no stall. Repeat with `id_uses_rs1`=0: no stall.
2. **MDU op.** `MDU_LATENCY`=4, `ex_mdu_start` pulsed at cycle 10 and held.
   - Stall and `ex_mem_flush`=1 in cycles 10–13.
   - `mdu_busy` high in cycles 11–14.
   - Enables all 1 at cycle 14; FSM back in IDLE at cycle 15.
   - `stall_cycles`=4.
3. **Redirect plus load-use in the same cycle.**
   - `if_id_flush`=1 and `id_ex_flush`=1, `pc_en`=1.
   - `redirect_flushes` increments by 1; `stall_cycles` is unchanged.
4. **Memory wait state.** `mem_ready`=0 for 3 cycles while `ex_redirect`=1.
   - All enables 0 and no flushes for those 3 cycles.
   - On the 4th cycle (`mem_ready`=1), the redirect flush occurs once.
   - `stall_cycles`=3.
5. **DONE hold.** MDU in DONE while `mem_ready`=0 for 2 cycles.
   - The FSM stays in DONE with no re-stall; it goes to IDLE after `mem_ready` returns to 1.
6. **Reset mid-BUSY.** Assert `reset` while `cnt`=7.
   - Next cycle: IDLE, `mdu_busy`=0, both counters 0.
   - With `CNT_W`=2, force 5 stalls: `stall_cycles` saturates at 3.
